// File: rtl/flag_selector.sv
// Flag index sequencer: debounced next/prev buttons step the mux selector modulo count, committed on frame_start.
// Optional auto-advance every AUTO_FRAMES frames is compiled in with `define FLAG_SELECTOR_AUTO_EN.
module flag_selector #(
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int AUTO_FRAMES     = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       auto_mode,
  input  logic [7:0] count,
  output logic [7:0] selector,
  output logic       changed
);

  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_FRAMES - 1);

  // Index 0 is the next button, index 1 the prev button.
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] deb_q, deb_d;
  logic [3:0] cnt_q [2];
  logic [3:0] cnt_d [2];
  logic [1:0] req;
  logic [7:0] sel_q, sel_d;
  logic       changed_q, changed_d;
  logic [7:0] n_eff, n_last;
  logic       auto_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {btn_prev, btn_next};
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    req   = '0;
    if (frame_start) begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
          cnt_d[i] = '0;
          req[i]   = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

`ifdef FLAG_SELECTOR_AUTO_EN
  localparam logic [15:0] AUTO_LAST = 16'(AUTO_FRAMES - 1);
  logic [15:0] auto_cnt_q, auto_cnt_d;

  // Any manual request, even an ignored both-pressed one, restarts the auto interval.
  always_comb begin
    auto_cnt_d = auto_cnt_q;
    auto_tick  = 1'b0;
    if (frame_start) begin
      if (!auto_mode || (|req)) begin
        auto_cnt_d = '0;
      end else if (auto_cnt_q == AUTO_LAST) begin
        auto_cnt_d = '0;
        auto_tick  = 1'b1;
      end else begin
        auto_cnt_d = auto_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) auto_cnt_q <= '0;
    else        auto_cnt_q <= auto_cnt_d;
  end
`else
  logic unused_auto_mode;
  assign unused_auto_mode = auto_mode;
  assign auto_tick        = 1'b0;
`endif

  assign n_eff  = (count == 8'd0) ? 8'd1 : count;
  assign n_last = n_eff - 8'd1;

  always_comb begin
    sel_d = sel_q;
    if (frame_start) begin
      if (sel_q >= n_eff) begin
        sel_d = '0;
      end else if (req[0] && req[1]) begin
        sel_d = sel_q;
      end else if (req[0] || auto_tick) begin
        sel_d = (sel_q == n_last) ? 8'd0 : sel_q + 8'd1;
      end else if (req[1]) begin
        sel_d = (sel_q == 8'd0) ? n_last : sel_q - 8'd1;
      end
    end
    changed_d = (sel_d != sel_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q     <= '0;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
      sel_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      changed_q <= changed_d;
    end
  end

  assign selector = sel_q;
  assign changed  = changed_q;

endmodule

// File: tb/tb_flag_selector.sv
// Directed bench for flag_selector: per-frame vector table plus hand sequences for reset, idle and auto-advance.
module tb_flag_selector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_prev = 1'b0;
  logic       auto_mode = 1'b0;
  logic [7:0] count = 8'd8;
  logic [7:0] selector;
  logic       changed;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       nxt;
    logic       prv;
    logic [7:0] cnt;
    logic [7:0] sel;
    logic       chg;
  } vec_t;

  vec_t tbl[$];

  flag_selector #(.DEBOUNCE_FRAMES(2), .AUTO_FRAMES(4)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .btn_next(btn_next), .btn_prev(btn_prev), .auto_mode(auto_mode),
    .count(count), .selector(selector), .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic n, input logic p, input logic [7:0] c,
                     input logic [7:0] s, input logic ch, input int reps);
    vec_t v;
    v.nxt = n; v.prv = p; v.cnt = c; v.sel = s; v.chg = ch;
    for (int k = 0; k < reps; k++) tbl.push_back(v);
  endtask

  // Apply inputs, let the synchronizers settle, pulse one strobe; returns at the
  // negedge right after the strobe edge, where the new selector/changed are visible.
  task automatic frame(input logic n, input logic p, input logic [7:0] c);
    btn_next = n; btn_prev = p; count = c;
    repeat (3) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic frame_chk(input string tag, input logic n, input logic p,
                           input logic [7:0] c, input logic [7:0] s, input logic ch);
    frame(n, p, c);
    chk({tag, "_sel"}, selector, s);
    chk({tag, "_chg"}, {7'd0, changed}, {7'd0, ch});
    @(negedge clk);
    chk({tag, "_chg_drop"}, {7'd0, changed}, 8'd0);
  endtask

  initial begin
    // next press held, release, glitch, prev, prev wrap, simultaneous, next wrap
    add(1,0,8, 0,0,1); add(1,0,8, 1,1,1); add(1,0,8, 1,0,4); add(0,0,8, 1,0,2);
    add(1,0,8, 1,0,1); add(0,0,8, 1,0,2);
    add(0,1,8, 1,0,1); add(0,1,8, 0,1,1); add(0,0,8, 0,0,2);
    add(0,1,8, 0,0,1); add(0,1,8, 7,1,1); add(0,0,8, 7,0,2);
    add(1,1,8, 7,0,2); add(0,0,8, 7,0,2);
    add(1,0,8, 7,0,1); add(1,0,8, 0,1,1); add(0,0,8, 0,0,2);
    // walk down to 5, then shrink count to 3 while a next press lands
    add(0,1,8, 0,0,1); add(0,1,8, 7,1,1); add(0,0,8, 7,0,2);
    add(0,1,8, 7,0,1); add(0,1,8, 6,1,1); add(0,0,8, 6,0,2);
    add(0,1,8, 6,0,1); add(0,1,8, 5,1,1); add(0,0,8, 5,0,2);
    add(1,0,8, 5,0,1); add(1,0,3, 0,1,1); add(1,0,3, 0,0,1); add(0,0,3, 0,0,2);
    // count 0 behaves as 1: next wraps 0 to 0, no change
    add(1,0,0, 0,0,2); add(0,0,0, 0,0,2);
    // next wrap at count 3
    add(1,0,3, 0,0,1); add(1,0,3, 1,1,1); add(0,0,3, 1,0,2);
    add(1,0,3, 1,0,1); add(1,0,3, 2,1,1); add(0,0,3, 2,0,2);
    add(1,0,3, 2,0,1); add(1,0,3, 0,1,1); add(0,0,3, 0,0,2);

    repeat (2) @(negedge clk);
    chk("reset_sel", selector, 8'd0);
    chk("reset_chg", {7'd0, changed}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i])
      frame_chk($sformatf("vec%0d", i), tbl[i].nxt, tbl[i].prv, tbl[i].cnt, tbl[i].sel, tbl[i].chg);

    // No strobe: a held button and a count change must do nothing
    btn_next = 1'b1; count = 8'd1;
    repeat (20) @(negedge clk);
    chk("idle_sel", selector, 8'd0);
    chk("idle_chg", {7'd0, changed}, 8'd0);
    btn_next = 1'b0; count = 8'd8;
    frame_chk("idle_rel", 0, 0, 8, 0, 0);

    // Asynchronous reset with changed high, no clock edge in between
    frame_chk("rp0", 0, 1, 8, 0, 0);
    frame(0, 1, 8);
    chk("rp1_sel", selector, 8'd7);
    chk("rp1_chg", {7'd0, changed}, 8'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_sel", selector, 8'd0);
    chk("async_rst_chg", {7'd0, changed}, 8'd0);
    btn_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // debounce state was reset too: prev is released, so one strobe alone is not enough
    frame_chk("post_rst", 0, 0, 8, 0, 0);

`ifdef FLAG_SELECTOR_AUTO_EN
    frame_chk("a_p0", 0, 1, 8, 0, 0);
    frame_chk("a_p1", 0, 1, 8, 7, 1);
    frame_chk("a_r0", 0, 0, 8, 7, 0);
    frame_chk("a_r1", 0, 0, 8, 7, 0);
    auto_mode = 1'b1;
    frame_chk("a_s1", 0, 0, 8, 7, 0);
    frame_chk("a_s2", 0, 0, 8, 7, 0);
    frame_chk("a_s3", 0, 0, 8, 7, 0);
    frame_chk("a_s4", 0, 0, 8, 0, 1);
    auto_mode = 1'b0;
    frame_chk("b_p0", 0, 1, 8, 0, 0);
    frame_chk("b_p1", 0, 1, 8, 7, 1);
    frame_chk("b_r0", 0, 0, 8, 7, 0);
    frame_chk("b_r1", 0, 0, 8, 7, 0);
    auto_mode = 1'b1;
    frame_chk("b_s1", 1, 0, 8, 7, 0);
    frame_chk("b_s2", 1, 0, 8, 0, 1);
    frame_chk("b_s3", 0, 0, 8, 0, 0);
    frame_chk("b_s4", 0, 0, 8, 0, 0);
    frame_chk("b_s5", 0, 0, 8, 0, 0);
    frame_chk("b_s6", 0, 0, 8, 1, 1);
    auto_mode = 1'b0;
`else
    auto_mode = 1'b1;
    for (int k = 0; k < 6; k++) frame_chk($sformatf("noauto%0d", k), 0, 0, 8, 0, 0);
    auto_mode = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
